// File: rtl/id_ex_register_pkg.sv
// Shared types for the ID/EX stage: ALU class encodings, opcode constants,
// the packed control-word bundle and a small reference decoder.
package id_ex_register_pkg;

   typedef enum logic [1:0] {
      I_TYPE  = 2'b00,
      S_TYPE  = 2'b01,
      R_TYPE  = 2'b10,
      SB_TYPE = 2'b11
   } aluop_e;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   // Bundle layout {RegWrite,MemtoReg,MemRead,MemWrite,ALUOp,ALUSrc,Branch}
   typedef struct packed {
      logic   reg_write;
      logic   mem_to_reg;
      logic   mem_read;
      logic   mem_write;
      aluop_e alu_op;
      logic   alu_src;
      logic   branch;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

   // Word loaded by reset and flush: nothing enabled, ALU class left at R.
   localparam ctrl_t CTRL_BUBBLE = '{reg_write: 1'b0, mem_to_reg: 1'b0, mem_read: 1'b0,
                                     mem_write: 1'b0, alu_op: R_TYPE, alu_src: 1'b0,
                                     branch: 1'b0};

   // Word captured for a non-instruction: every control field literally zero.
   localparam ctrl_t CTRL_ZERO = '{reg_write: 1'b0, mem_to_reg: 1'b0, mem_read: 1'b0,
                                   mem_write: 1'b0, alu_op: I_TYPE, alu_src: 1'b0,
                                   branch: 1'b0};

   // Main-decoder control word for the supported opcode classes.
   function automatic ctrl_t decode_ctrl(input logic [6:0] opcode);
      ctrl_t c;
      c = CTRL_BUBBLE;
      case (opcode)
         OPC_R: begin
            c.reg_write = 1'b1;
            c.alu_op    = R_TYPE;
         end
         OPC_I: begin
            c.reg_write = 1'b1;
            c.alu_op    = I_TYPE;
            c.alu_src   = 1'b1;
         end
         OPC_LOAD: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
            c.mem_read   = 1'b1;
            c.alu_op     = I_TYPE;
            c.alu_src    = 1'b1;
         end
         OPC_STORE: begin
            c.mem_write = 1'b1;
            c.alu_op    = S_TYPE;
            c.alu_src   = 1'b1;
         end
         OPC_BRANCH: begin
            c.branch = 1'b1;
            c.alu_op = SB_TYPE;
         end
         default: c = CTRL_BUBBLE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/id_ex_register_if.sv
// ID-to-EX bundle: hazard controls and ID-side fields in, registered EX-side copies out.
interface id_ex_register_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
);
   logic              stall_i;
   logic              flush_i;
   logic              valid_i;
   logic              RegWrite_i;
   logic              MemtoReg_i;
   logic              MemRead_i;
   logic              MemWrite_i;
   logic              ALUSrc_i;
   logic              Branch_i;
   logic [1:0]        ALUOp_i;
   logic [DATA_W-1:0] rs1_data_i;
   logic [DATA_W-1:0] rs2_data_i;
   logic [DATA_W-1:0] imm_i;
   logic [DATA_W-1:0] pc_i;
   logic [9:0]        funct_i;
   logic [ADDR_W-1:0] rs1_i;
   logic [ADDR_W-1:0] rs2_i;
   logic [ADDR_W-1:0] rd_i;

   logic              valid_o;
   logic              RegWrite_o;
   logic              MemtoReg_o;
   logic              MemRead_o;
   logic              MemWrite_o;
   logic              ALUSrc_o;
   logic              Branch_o;
   logic [1:0]        ALUOp_o;
   logic [DATA_W-1:0] rs1_data_o;
   logic [DATA_W-1:0] rs2_data_o;
   logic [DATA_W-1:0] imm_o;
   logic [DATA_W-1:0] pc_o;
   logic [9:0]        funct_o;
   logic [ADDR_W-1:0] rs1_o;
   logic [ADDR_W-1:0] rs2_o;
   logic [ADDR_W-1:0] rd_o;
   logic [CNT_W-1:0]  bubble_cnt_o;

   modport master (
      output stall_i, flush_i, valid_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i,
             ALUSrc_i, Branch_i, ALUOp_i, rs1_data_i, rs2_data_i, imm_i, pc_i, funct_i,
             rs1_i, rs2_i, rd_i,
      input  valid_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, Branch_o,
             ALUOp_o, rs1_data_o, rs2_data_o, imm_o, pc_o, funct_o, rs1_o, rs2_o, rd_o,
             bubble_cnt_o
   );

   modport slave (
      input  stall_i, flush_i, valid_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i,
             ALUSrc_i, Branch_i, ALUOp_i, rs1_data_i, rs2_data_i, imm_i, pc_i, funct_i,
             rs1_i, rs2_i, rd_i,
      output valid_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, Branch_o,
             ALUOp_o, rs1_data_o, rs2_data_o, imm_o, pc_o, funct_o, rs1_o, rs2_o, rd_o,
             bubble_cnt_o
   );
endinterface

// File: rtl/pipe_field_reg.sv
// W-bit pipeline field: async active-low reset, load enable (hold when low)
// and a synchronous clear that takes priority over the load.
module pipe_field_reg #(
   parameter int           W       = 8,
   parameter logic [W-1:0] RST_VAL = '0,
   parameter logic [W-1:0] CLR_VAL = '0
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         en_i,
   input  logic         clr_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   logic [W-1:0] field_q;
   logic [W-1:0] field_d;

   // Next value: clear beats load, otherwise hold.
   always_comb begin
      field_d = field_q;
      if (clr_i) begin
         field_d = CLR_VAL;
      end else if (en_i) begin
         field_d = d_i;
      end
   end

   // Field storage.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         field_q <= RST_VAL;
      end else begin
         field_q <= field_d;
      end
   end

   assign q_o = field_q;
endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register: control word and operand payload with stall/flush,
// a per-stage valid bit and a saturating count of bubbles entering EX.
module id_ex_register #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   id_ex_register_if.slave bus
);
   import id_ex_register_pkg::*;

   localparam int PAY_W = 4 * DATA_W + 10 + 3 * ADDR_W;

   ctrl_t             id_ctrl;
   ctrl_t             ctrl_cap;
   ctrl_t             ctrl_q;
   logic [CTRL_W-1:0] ctrl_raw;
   logic [PAY_W-1:0]  pay_cap;
   logic [PAY_W-1:0]  pay_q;
   logic              load_en;
   logic              bubble_in;
   logic              valid_q;
   logic              valid_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   assign load_en   = ~bus.stall_i;
   // A bubble enters EX on a flush, or on a normal capture of a non-instruction.
   assign bubble_in = bus.flush_i | (~bus.stall_i & ~bus.valid_i);

   // Control word to capture; a non-instruction carries no enables so EX/MEM/WB stay quiet.
   always_comb begin
      id_ctrl = CTRL_ZERO;
      id_ctrl.reg_write  = bus.RegWrite_i;
      id_ctrl.mem_to_reg = bus.MemtoReg_i;
      id_ctrl.mem_read   = bus.MemRead_i;
      id_ctrl.mem_write  = bus.MemWrite_i;
      id_ctrl.alu_op     = aluop_e'(bus.ALUOp_i);
      id_ctrl.alu_src    = bus.ALUSrc_i;
      id_ctrl.branch     = bus.Branch_i;
      ctrl_cap = bus.valid_i ? id_ctrl : CTRL_ZERO;
   end

   assign pay_cap = {bus.rs1_data_i, bus.rs2_data_i, bus.imm_i, bus.pc_i,
                     bus.funct_i, bus.rs1_i, bus.rs2_i, bus.rd_i};

   pipe_field_reg #(
      .W       (CTRL_W),
      .RST_VAL (CTRL_BUBBLE),
      .CLR_VAL (CTRL_BUBBLE)
   ) u_ctrl_reg (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (load_en),
      .clr_i (bus.flush_i),
      .d_i   (ctrl_cap),
      .q_o   (ctrl_raw)
   );

   pipe_field_reg #(
      .W       (PAY_W),
      .RST_VAL ('0),
      .CLR_VAL ('0)
   ) u_pay_reg (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (load_en),
      .clr_i (bus.flush_i),
      .d_i   (pay_cap),
      .q_o   (pay_q)
   );

   assign ctrl_q = ctrl_t'(ctrl_raw);

   // Valid and bubble-counter next state: flush > stall > normal.
   always_comb begin
      valid_d = valid_q;
      cnt_d   = cnt_q;
      if (bus.flush_i) begin
         valid_d = 1'b0;
      end else if (!bus.stall_i) begin
         valid_d = bus.valid_i;
      end
      if (bubble_in) begin
         cnt_d = sat_inc(cnt_q);
      end
   end

   // Valid flop and bubble counter storage.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.valid_o      = valid_q;
   assign bus.bubble_cnt_o = cnt_q;
   assign bus.RegWrite_o   = ctrl_q.reg_write;
   assign bus.MemtoReg_o   = ctrl_q.mem_to_reg;
   assign bus.MemRead_o    = ctrl_q.mem_read;
   assign bus.MemWrite_o   = ctrl_q.mem_write;
   assign bus.ALUOp_o      = ctrl_q.alu_op;
   assign bus.ALUSrc_o     = ctrl_q.alu_src;
   assign bus.Branch_o     = ctrl_q.branch;
   assign {bus.rs1_data_o, bus.rs2_data_o, bus.imm_o, bus.pc_o,
           bus.funct_o, bus.rs1_o, bus.rs2_o, bus.rd_o} = pay_q;
endmodule

// File: tb/tb_id_ex_register.sv
// Bench for id_ex_register: a 16-bit-counter instance and a 4-bit-counter
// instance share one stimulus stream and are compared with a cycle model.
module tb_id_ex_register;
   import id_ex_register_pkg::*;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int PAY_W  = 4 * DATA_W + 10 + 3 * ADDR_W;
   localparam int ALL_W  = 8 + PAY_W + 1;
   localparam logic [7:0] CTRL_RST = 8'b0000_1000;
   localparam logic [7:0] CTRL_INV = 8'b0000_0000;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   id_ex_register_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(16)) bus ();
   id_ex_register_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(4))  bus4 ();

   id_ex_register #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(16)) dut (
      .clk_i (clk), .rst_i (rst_n), .bus (bus));
   id_ex_register #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(4)) dut4 (
      .clk_i (clk), .rst_i (rst_n), .bus (bus4));

   assign bus4.stall_i    = bus.stall_i;
   assign bus4.flush_i    = bus.flush_i;
   assign bus4.valid_i    = bus.valid_i;
   assign bus4.RegWrite_i = bus.RegWrite_i;
   assign bus4.MemtoReg_i = bus.MemtoReg_i;
   assign bus4.MemRead_i  = bus.MemRead_i;
   assign bus4.MemWrite_i = bus.MemWrite_i;
   assign bus4.ALUSrc_i   = bus.ALUSrc_i;
   assign bus4.Branch_i   = bus.Branch_i;
   assign bus4.ALUOp_i    = bus.ALUOp_i;
   assign bus4.rs1_data_i = bus.rs1_data_i;
   assign bus4.rs2_data_i = bus.rs2_data_i;
   assign bus4.imm_i      = bus.imm_i;
   assign bus4.pc_i       = bus.pc_i;
   assign bus4.funct_i    = bus.funct_i;
   assign bus4.rs1_i      = bus.rs1_i;
   assign bus4.rs2_i      = bus.rs2_i;
   assign bus4.rd_i       = bus.rd_i;

   logic [7:0]       in_ctrl;
   logic [PAY_W-1:0] in_pay;
   logic [ALL_W-1:0] obs_all;
   logic [ALL_W-1:0] obs4_all;

   assign in_ctrl = {bus.RegWrite_i, bus.MemtoReg_i, bus.MemRead_i, bus.MemWrite_i,
                     bus.ALUOp_i, bus.ALUSrc_i, bus.Branch_i};
   assign in_pay  = {bus.rs1_data_i, bus.rs2_data_i, bus.imm_i, bus.pc_i,
                     bus.funct_i, bus.rs1_i, bus.rs2_i, bus.rd_i};
   assign obs_all = {bus.RegWrite_o, bus.MemtoReg_o, bus.MemRead_o, bus.MemWrite_o,
                     bus.ALUOp_o, bus.ALUSrc_o, bus.Branch_o,
                     bus.rs1_data_o, bus.rs2_data_o, bus.imm_o, bus.pc_o,
                     bus.funct_o, bus.rs1_o, bus.rs2_o, bus.rd_o, bus.valid_o};
   assign obs4_all = {bus4.RegWrite_o, bus4.MemtoReg_o, bus4.MemRead_o, bus4.MemWrite_o,
                      bus4.ALUOp_o, bus4.ALUSrc_o, bus4.Branch_o,
                      bus4.rs1_data_o, bus4.rs2_data_o, bus4.imm_o, bus4.pc_o,
                      bus4.funct_o, bus4.rs1_o, bus4.rs2_o, bus4.rd_o, bus4.valid_o};

   // Reference state: what EX should see, and how many bubbles have entered EX.
   logic [7:0]       exp_ctrl;
   logic [PAY_W-1:0] exp_pay;
   logic             exp_valid;
   int               bubbles;
   logic [ALL_W-1:0] exp_all;

   assign exp_all = {exp_ctrl, exp_pay, exp_valid};

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_reset();
      exp_ctrl  = CTRL_RST;
      exp_pay   = '0;
      exp_valid = 1'b0;
      bubbles   = 0;
   endtask

   task automatic model_edge();
      if (bus.flush_i) begin
         exp_ctrl  = CTRL_RST;
         exp_pay   = '0;
         exp_valid = 1'b0;
         bubbles   = bubbles + 1;
      end else if (!bus.stall_i) begin
         exp_pay   = in_pay;
         exp_valid = bus.valid_i;
         if (bus.valid_i) begin
            exp_ctrl = in_ctrl;
         end else begin
            exp_ctrl = CTRL_INV;
            bubbles  = bubbles + 1;
         end
      end
   endtask

   task automatic drive_rand(input logic flush, input logic stall, input logic valid);
      bus.flush_i    = flush;
      bus.stall_i    = stall;
      bus.valid_i    = valid;
      {bus.RegWrite_i, bus.MemtoReg_i, bus.MemRead_i, bus.MemWrite_i,
       bus.ALUOp_i, bus.ALUSrc_i, bus.Branch_i} = 8'($urandom);
      bus.rs1_data_i = $urandom;
      bus.rs2_data_i = $urandom;
      bus.imm_i      = $urandom;
      bus.pc_i       = $urandom;
      bus.funct_i    = 10'($urandom);
      bus.rs1_i      = 5'($urandom);
      bus.rs2_i      = 5'($urandom);
      bus.rd_i       = 5'($urandom);
   endtask

   task automatic set_ctrl(input ctrl_t c);
      {bus.RegWrite_i, bus.MemtoReg_i, bus.MemRead_i, bus.MemWrite_i,
       bus.ALUOp_i, bus.ALUSrc_i, bus.Branch_i} = c;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic pulse_reset();
      #2 rst_n = 1'b0;
      model_reset();
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      drive_rand(1'b0, 1'b0, 1'b1);
      bus.RegWrite_i = 1'b1;
      cycle();
      drive_rand(1'b0, 1'b0, 1'b1);
      cycle();
      drive_rand(1'b1, 1'b1, 1'b1);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (obs_all !== exp_all) begin
         errors++;
         $display("FAIL reset_outputs: got %h want %h", obs_all, exp_all);
      end
      checks++;
      if (bus.ALUOp_o !== 2'b10) begin
         errors++;
         $display("FAIL reset_aluop: got %b want 10", bus.ALUOp_o);
      end
      checks++;
      if (bus.bubble_cnt_o !== 16'd0 || bus4.bubble_cnt_o !== 4'd0) begin
         errors++;
         $display("FAIL reset_cnt: got %0d/%0d want 0", bus.bubble_cnt_o, bus4.bubble_cnt_o);
      end
      #1 rst_n = 1'b1;
   endtask

   task automatic test_pass_through();
      int b0;
      b0 = bubbles;
      drive_rand(1'b0, 1'b0, 1'b1);
      set_ctrl(decode_ctrl(OPC_R));
      bus.rs1_data_i = 32'h0000_0005;
      bus.rd_i       = 5'd7;
      cycle();
      checks++;
      if (bus.RegWrite_o !== 1'b1 || bus.ALUOp_o !== 2'b10 || bus.rs1_data_o !== 32'h5 ||
          bus.rd_o !== 5'd7 || bus.valid_o !== 1'b1) begin
         errors++;
         $display("FAIL pass_fields: got rw=%b op=%b rs1d=%h rd=%0d v=%b want 1 10 5 7 1",
                  bus.RegWrite_o, bus.ALUOp_o, bus.rs1_data_o, bus.rd_o, bus.valid_o);
      end
      checks++;
      if (obs_all !== exp_all) begin
         errors++;
         $display("FAIL pass_all: got %h want %h", obs_all, exp_all);
      end
      checks++;
      if (bus.bubble_cnt_o !== 16'(sat(b0, 65535))) begin
         errors++;
         $display("FAIL pass_cnt: got %0d want %0d", bus.bubble_cnt_o, sat(b0, 65535));
      end
   endtask

   task automatic test_stall();
      int b0;
      drive_rand(1'b0, 1'b0, 1'b1);
      set_ctrl(decode_ctrl(OPC_LOAD));
      bus.imm_i = 32'h0000_0010;
      cycle();
      b0 = bubbles;
      for (int i = 0; i < 3; i++) begin
         drive_rand(1'b0, 1'b1, 1'($urandom));
         cycle();
         checks++;
         if (bus.MemRead_o !== 1'b1 || bus.MemtoReg_o !== 1'b1 || bus.imm_o !== 32'h10) begin
            errors++;
            $display("FAIL stall_lw[%0d]: got mr=%b m2r=%b imm=%h want 1 1 10",
                     i, bus.MemRead_o, bus.MemtoReg_o, bus.imm_o);
         end
         checks++;
         if (obs_all !== exp_all) begin
            errors++;
            $display("FAIL stall_all[%0d]: got %h want %h", i, obs_all, exp_all);
         end
         checks++;
         if (bus.bubble_cnt_o !== 16'(sat(b0, 65535))) begin
            errors++;
            $display("FAIL stall_cnt[%0d]: got %0d want %0d", i, bus.bubble_cnt_o, sat(b0, 65535));
         end
      end
   endtask

   task automatic test_flush_vs_stall();
      int b0;
      b0 = bubbles;
      drive_rand(1'b1, 1'b1, 1'b1);
      set_ctrl(decode_ctrl(OPC_STORE));
      cycle();
      checks++;
      if (bus.MemWrite_o !== 1'b0 || bus.valid_o !== 1'b0) begin
         errors++;
         $display("FAIL flush_sw: got mw=%b v=%b want 0 0", bus.MemWrite_o, bus.valid_o);
      end
      checks++;
      if (bus.bubble_cnt_o !== 16'(sat(b0 + 1, 65535))) begin
         errors++;
         $display("FAIL flush_cnt: got %0d want %0d", bus.bubble_cnt_o, sat(b0 + 1, 65535));
      end
      checks++;
      if (obs_all !== exp_all) begin
         errors++;
         $display("FAIL flush_all: got %h want %h", obs_all, exp_all);
      end
   endtask

   task automatic test_invalid_capture();
      int b0;
      b0 = bubbles;
      drive_rand(1'b0, 1'b0, 1'b0);
      bus.RegWrite_i = 1'b1;
      bus.MemWrite_i = 1'b1;
      cycle();
      checks++;
      if (bus.RegWrite_o !== 1'b0 || bus.MemWrite_o !== 1'b0 || bus.valid_o !== 1'b0) begin
         errors++;
         $display("FAIL invalid_ctrl: got rw=%b mw=%b v=%b want 0 0 0",
                  bus.RegWrite_o, bus.MemWrite_o, bus.valid_o);
      end
      checks++;
      if (bus.bubble_cnt_o !== 16'(sat(b0 + 1, 65535))) begin
         errors++;
         $display("FAIL invalid_cnt: got %0d want %0d", bus.bubble_cnt_o, sat(b0 + 1, 65535));
      end
      checks++;
      if (obs_all !== exp_all) begin
         errors++;
         $display("FAIL invalid_all: got %h want %h", obs_all, exp_all);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive_rand(1'($urandom_range(7) == 0), 1'($urandom_range(3) == 0),
                    1'($urandom_range(3) != 0));
         cycle();
         checks++;
         if (obs_all !== exp_all || obs4_all !== exp_all) begin
            errors++;
            $display("FAIL rand_all[%0d]: got %h / %h want %h", i, obs_all, obs4_all, exp_all);
         end
         checks++;
         if (bus.bubble_cnt_o !== 16'(sat(bubbles, 65535)) ||
             bus4.bubble_cnt_o !== 4'(sat(bubbles, 15))) begin
            errors++;
            $display("FAIL rand_cnt[%0d]: got %0d/%0d want %0d/%0d", i, bus.bubble_cnt_o,
                     bus4.bubble_cnt_o, sat(bubbles, 65535), sat(bubbles, 15));
         end
         checks++;
         if (!bus.valid_o && (bus.RegWrite_o || bus.MemRead_o || bus.MemWrite_o || bus.Branch_o)) begin
            errors++;
            $display("FAIL rand_invariant[%0d]: got rw=%b mr=%b mw=%b br=%b with valid 0, want all 0",
                     i, bus.RegWrite_o, bus.MemRead_o, bus.MemWrite_o, bus.Branch_o);
         end
      end
   endtask

   task automatic test_saturation();
      pulse_reset();
      for (int i = 0; i < 20; i++) begin
         drive_rand(1'b1, 1'($urandom), 1'($urandom));
         cycle();
         checks++;
         if (bus4.bubble_cnt_o !== 4'(sat(bubbles, 15))) begin
            errors++;
            $display("FAIL sat_cnt4[%0d]: got %0d want %0d", i, bus4.bubble_cnt_o, sat(bubbles, 15));
         end
      end
      checks++;
      if (bus4.bubble_cnt_o !== 4'd15) begin
         errors++;
         $display("FAIL sat_final: got %0d want 15", bus4.bubble_cnt_o);
      end
      checks++;
      if (bus.bubble_cnt_o !== 16'(sat(bubbles, 65535))) begin
         errors++;
         $display("FAIL sat_cnt16: got %0d want %0d", bus.bubble_cnt_o, sat(bubbles, 65535));
      end
   endtask

   initial begin
      model_reset();
      drive_rand(1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      test_reset();
      test_pass_through();
      test_stall();
      test_flush_vs_stall();
      test_invalid_capture();
      test_random();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
